// File: rtl/axis_block_sig_gen_pkg.sv
// Shared types and helpers for the AXI-Stream block flag generator.
package axis_block_pkg;

  // Upper bound on observed channels; first_ch is 5 bits wide.
  localparam int MAX_CH    = 32;
  // Default stall counter width and its saturation value.
  localparam int CNT_W_DEF = 16;
  localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

  // Report FSM: waiting for the first block, or inside a block episode.
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_BLOCKED = 1'b1
  } blk_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set_index(input logic [MAX_CH-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = i[4:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_block_sig_gen_if.sv
// Channel handshake observation and block report bundle.
interface axis_block_if #(
  parameter int NUM_CH = 1,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0] ch_tvalid;
  logic [NUM_CH-1:0] ch_tready;
  logic              inst_idle;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic              block_enter;
  logic              block_release;
  logic [4:0]        first_ch;
  logic [CNT_W-1:0]  first_cycles;

  // Environment side: drives the observed handshakes, reads the report.
  modport master (
    output ch_tvalid, ch_tready, inst_idle,
    input  axis_block_sigs, any_block, block_enter, block_release,
           first_ch, first_cycles
  );

  // Generator side.
  modport slave (
    input  ch_tvalid, ch_tready, inst_idle,
    output axis_block_sigs, any_block, block_enter, block_release,
           first_ch, first_cycles
  );
endinterface

// File: rtl/axis_block_sig_gen_stall_counter.sv
// Per-channel stall detector, saturating consecutive-stall counter and
// block flag. Exposes next-state values so the top can make its FSM
// decision on the same edge the flags change.
module axis_stall_counter #(
  parameter int CNT_W        = 16,
  parameter int STALL_THRESH = 16,
  parameter bit IS_INPUT     = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tvalid,
  input  logic             tready,
  input  logic             inst_idle,
  output logic [CNT_W-1:0] cnt_d,
  output logic             flag_d,
  output logic             flag_q
);

  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESH - 1);

  logic             stall_raw;
  logic             stall;
  logic [CNT_W-1:0] cnt_q;

  // Stall = waiting on the peer: inputs starve (ready, no data), outputs
  // back up (data, no ready). An idle instance never stalls.
  always_comb begin
    stall_raw = IS_INPUT ? (tready & ~tvalid) : (tvalid & ~tready);
    stall     = stall_raw & ~inst_idle;
  end

  // Count consecutive stall cycles (saturating); the flag is up while the
  // run, including this cycle, has reached the threshold.
  always_comb begin
    cnt_d  = '0;
    flag_d = 1'b0;
    if (stall) begin
      cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      flag_d = (cnt_q >= THRESH_M1);
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/axis_block_sig_gen.sv
// Per-channel AXIS block flags plus a block episode reporter: one-cycle
// enter/release pulses, the first blocked channel and its live stall count.
module axis_block_sig_gen
  import axis_block_pkg::*;
#(
  parameter int          NUM_CH       = 1,
  parameter logic [31:0] IN_MASK      = 32'h1,
  parameter int          STALL_THRESH = 16,
  parameter int          CNT_W        = CNT_W_DEF
) (
  input logic        clock,
  input logic        reset,
  axis_block_if.slave bus
);

  // Vectors are padded to MAX_CH so a 5-bit channel index is always in range.
  logic [MAX_CH-1:0]            flag_d;
  logic [MAX_CH-1:0]            flag_q;
  logic [MAX_CH-1:0][CNT_W-1:0] cnt_d;

  for (genvar i = 0; i < MAX_CH; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      axis_stall_counter #(
        .CNT_W       (CNT_W),
        .STALL_THRESH(STALL_THRESH),
        .IS_INPUT    (IN_MASK[i])
      ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .tvalid   (bus.ch_tvalid[i]),
        .tready   (bus.ch_tready[i]),
        .inst_idle(bus.inst_idle),
        .cnt_d    (cnt_d[i]),
        .flag_d   (flag_d[i]),
        .flag_q   (flag_q[i])
      );
    end else begin : g_off
      assign cnt_d[i]  = '0;
      assign flag_d[i] = 1'b0;
      assign flag_q[i] = 1'b0;
    end
  end

  blk_state_t       state_q, state_d;
  logic             any_block_q, any_block_d;
  logic             block_enter_q, block_enter_d;
  logic             block_release_q, block_release_d;
  logic [4:0]       first_ch_q, first_ch_d;
  logic [CNT_W-1:0] first_cycles_q, first_cycles_d;
  logic [4:0]       low_idx;

  // Episode FSM next state: decisions use next-state flags so pulses and
  // captures line up with the edge where the flags themselves change.
  always_comb begin
    state_d         = state_q;
    any_block_d     = |flag_d;
    block_enter_d   = 1'b0;
    block_release_d = 1'b0;
    first_ch_d      = first_ch_q;
    first_cycles_d  = first_cycles_q;
    low_idx         = lowest_set_index(flag_d);
    case (state_q)
      S_IDLE: begin
        if (any_block_d) begin
          state_d        = S_BLOCKED;
          block_enter_d  = 1'b1;
          first_ch_d     = low_idx;
          first_cycles_d = cnt_d[low_idx];
        end
      end
      S_BLOCKED: begin
        if (!any_block_d) begin
          state_d         = S_IDLE;
          block_release_d = 1'b1;
        end else if (flag_d[first_ch_q]) begin
          // Follow the captured channel only while it is still blocked.
          first_cycles_d = cnt_d[first_ch_q];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Episode FSM and report registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      any_block_q     <= 1'b0;
      block_enter_q   <= 1'b0;
      block_release_q <= 1'b0;
      first_ch_q      <= '0;
      first_cycles_q  <= '0;
    end else begin
      state_q         <= state_d;
      any_block_q     <= any_block_d;
      block_enter_q   <= block_enter_d;
      block_release_q <= block_release_d;
      first_ch_q      <= first_ch_d;
      first_cycles_q  <= first_cycles_d;
    end
  end

  assign bus.axis_block_sigs = flag_q[NUM_CH-1:0];
  assign bus.any_block       = any_block_q;
  assign bus.block_enter     = block_enter_q;
  assign bus.block_release   = block_release_q;
  assign bus.first_ch        = first_ch_q;
  assign bus.first_cycles    = first_cycles_q;

endmodule

// File: tb/tb_axis_block_sig_gen.sv
// Self-checking bench: vector table and hand sequences on small configs,
// then randomized traffic on a 3-channel config against a run-length model.
module tb_axis_block_sig_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // A: 1 input channel, thresh 4. B: 1 input channel, 3-bit counter, thresh 2.
  // C: 3 channels, ch0 input, ch1/ch2 outputs, thresh 4.
  axis_block_if #(.NUM_CH(1), .CNT_W(16)) if_a ();
  axis_block_if #(.NUM_CH(1), .CNT_W(3))  if_b ();
  axis_block_if #(.NUM_CH(3), .CNT_W(16)) if_c ();

  axis_block_sig_gen #(.NUM_CH(1), .IN_MASK(32'h1), .STALL_THRESH(4), .CNT_W(16))
    dut_a (.clock(clock), .reset(reset), .bus(if_a));
  axis_block_sig_gen #(.NUM_CH(1), .IN_MASK(32'h1), .STALL_THRESH(2), .CNT_W(3))
    dut_b (.clock(clock), .reset(reset), .bus(if_b));
  axis_block_sig_gen #(.NUM_CH(3), .IN_MASK(32'h1), .STALL_THRESH(4), .CNT_W(16))
    dut_c (.clock(clock), .reset(reset), .bus(if_c));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Checks dut A's full report (single channel, so first_ch must be 0).
  task automatic chk_a(input string tag, input logic flag, input logic enter,
                       input logic rel, input int fc);
    chk({tag, ".flag"},  if_a.axis_block_sigs, flag);
    chk({tag, ".any"},   if_a.any_block, flag);
    chk({tag, ".enter"}, if_a.block_enter, enter);
    chk({tag, ".rel"},   if_a.block_release, rel);
    chk({tag, ".fch"},   if_a.first_ch, 0);
    chk({tag, ".fcyc"},  if_a.first_cycles, fc);
  endtask

  typedef struct {
    logic tv;
    logic tr;
    logic flag;
    logic enter;
    logic rel;
    int   fc;
  } vec_t;

  function automatic vec_t mk(input logic tv, input logic tr, input logic flag,
                              input logic enter, input logic rel, input int fc);
    vec_t v;
    v.tv = tv; v.tr = tr; v.flag = flag; v.enter = enter; v.rel = rel; v.fc = fc;
    return v;
  endfunction

  // Reference model state for the random phase on dut C.
  int   run [3];
  bit   m_flag [3];
  bit   m_blocked;
  int   m_first;
  int   m_fc;
  logic [2:0] tv_r, tr_r;

  initial begin
    vec_t vt[$];

    if_a.ch_tvalid = '0; if_a.ch_tready = '0; if_a.inst_idle = 1'b0;
    if_b.ch_tvalid = '0; if_b.ch_tready = '0; if_b.inst_idle = 1'b0;
    if_c.ch_tvalid = '0; if_c.ch_tready = '0; if_c.inst_idle = 1'b0;

    reset = 1'b1;
    tick(); tick();
    chk_a("reset_a", 1'b0, 1'b0, 1'b0, 0);
    chk("reset_c.sigs", if_c.axis_block_sigs, 0);
    reset = 1'b0;

    // Test 1: stall from cycle 0, handshake at cycle 10. Then test 2:
    // interrupted stalls never flag; first_cycles stays frozen at 10.
    for (int k = 0; k < 10; k++)
      vt.push_back(mk(1'b0, 1'b1, (k + 1 >= 4), (k + 1 == 4), 1'b0, (k + 1 >= 4) ? k + 1 : 0));
    vt.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10));
    for (int k = 0; k < 3; k++) vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10));
    vt.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10));
    for (int k = 0; k < 3; k++) vt.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10));
    vt.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10));

    foreach (vt[i]) begin
      if_a.ch_tvalid = vt[i].tv;
      if_a.ch_tready = vt[i].tr;
      tick();
      chk_a($sformatf("vec%0d", i), vt[i].flag, vt[i].enter, vt[i].rel, vt[i].fc);
    end

    // Test 5: block, then instance goes idle mid-block.
    if_a.ch_tvalid = 1'b0; if_a.ch_tready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) chk_a("idle_pre_enter", 1'b1, 1'b1, 1'b0, 4);
    end
    chk_a("idle_pre_blk", 1'b1, 1'b0, 1'b0, 6);
    if_a.inst_idle = 1'b1;
    tick();
    chk_a("idle_release", 1'b0, 1'b0, 1'b1, 6);
    if_a.inst_idle = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) chk_a("idle_restart3", 1'b0, 1'b0, 1'b0, 6);
    end
    chk_a("idle_restart4", 1'b1, 1'b1, 1'b0, 4);

    // Test 6: one-cycle reset mid-block, no release, then re-detect.
    tick(); tick();
    reset = 1'b1;
    tick();
    chk_a("rst_mid", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) chk_a("rst_re3", 1'b0, 1'b0, 1'b0, 0);
    end
    chk_a("rst_re4", 1'b1, 1'b1, 1'b0, 4);
    if_a.ch_tready = 1'b0;

    // Test 3: 3-bit counter saturates at 7 without wrapping.
    if_b.ch_tvalid = 1'b0; if_b.ch_tready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat%0d.flag", k), if_b.axis_block_sigs, (k >= 2));
      chk($sformatf("sat%0d.fcyc", k), if_b.first_cycles, (k >= 2) ? ((k < 7) ? k : 7) : 0);
    end
    if_b.ch_tvalid = 1'b1;
    tick();
    chk("sat_release", {if_b.axis_block_sigs, if_b.block_release, if_b.first_cycles}, {1'b0, 1'b1, 3'd7});
    if_b.ch_tvalid = 1'b0; if_b.ch_tready = 1'b0;

    // Test 4: two output channels cross threshold together.
    if_c.ch_tvalid = 3'b110; if_c.ch_tready = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("multi%0d.sigs", k), if_c.axis_block_sigs, 3'b000);
    end
    tick();
    chk("multi.sigs",  if_c.axis_block_sigs, 3'b110);
    chk("multi.enter", if_c.block_enter, 1'b1);
    chk("multi.fch",   if_c.first_ch, 1);
    chk("multi.fcyc",  if_c.first_cycles, 4);
    // First channel clears while ch2 stays blocked: first_ch and count hold.
    if_c.ch_tvalid = 3'b100;
    tick(); tick();
    chk("multi_drop.sigs", if_c.axis_block_sigs, 3'b100);
    chk("multi_drop.fch",  if_c.first_ch, 1);
    chk("multi_drop.fcyc", if_c.first_cycles, 4);
    chk("multi_drop.enter", if_c.block_enter, 1'b0);
    if_c.ch_tvalid = 3'b000;
    tick();
    chk("multi_rel", {if_c.block_release, if_c.any_block}, 2'b10);

    // Random phase on dut C against the run-length model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    foreach (run[i]) begin run[i] = 0; m_flag[i] = 1'b0; end
    m_blocked = 1'b0; m_first = 0; m_fc = 0;
    tv_r = '0; tr_r = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit any_n, enter_e, rel_e, idle;
      logic [2:0] exp_sigs;
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          tv_r[c] = $urandom_range(0, 1);
          tr_r[c] = $urandom_range(0, 1);
        end
      end
      idle = ($urandom_range(0, 39) == 0);
      if_c.ch_tvalid = tv_r; if_c.ch_tready = tr_r; if_c.inst_idle = idle;
      tick();
      // Stall run lengths: ch0 starves, ch1/ch2 back up.
      any_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
        bit st;
        st = !idle && ((c == 0) ? (tr_r[c] && !tv_r[c]) : (tv_r[c] && !tr_r[c]));
        run[c] = st ? ((run[c] < 65535) ? run[c] + 1 : 65535) : 0;
        m_flag[c] = (run[c] >= 4);
        exp_sigs[c] = m_flag[c];
        any_n |= m_flag[c];
      end
      enter_e = !m_blocked && any_n;
      rel_e   = m_blocked && !any_n;
      if (enter_e) begin
        m_first = m_flag[0] ? 0 : (m_flag[1] ? 1 : 2);
        m_fc    = run[m_first];
      end else if (m_blocked && any_n && m_flag[m_first]) begin
        m_fc = run[m_first];
      end
      m_blocked = any_n;
      chk($sformatf("rnd%0d.sigs", cyc), if_c.axis_block_sigs, exp_sigs);
      chk($sformatf("rnd%0d.pulse", cyc),
          {if_c.any_block, if_c.block_enter, if_c.block_release}, {any_n, enter_e, rel_e});
      chk($sformatf("rnd%0d.first", cyc), {if_c.first_ch, if_c.first_cycles},
          {5'(m_first), 16'(m_fc)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_block_sig_gen.md
Name: axis_block_sig_gen

Overview:
- Producer of the per-channel AXI-Stream block flags consumed by the deadlock monitors in the HLS co-simulation wrapper.
- Watches TVALID/TREADY on each AXIS port of one instance and raises a channel's block flag once that port has stalled for STALL_THRESH consecutive cycles.
- A small FSM produces one-cycle enter/release event pulses and latches the first blocked channel and its stall length for the report logic.

Parameters:
- NUM_CH, 1: number of AXIS channels observed (1..32).
- IN_MASK, 1: bit i=1 means channel i is an input to the instance (stalls on empty); 0 means an output (stalls on full).
- STALL_THRESH, 16: consecutive stall cycles before a block flag asserts; legal range 1..2^CNT_W-1.
- CNT_W, 16: stall counter width.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- ch_tvalid  in  NUM_CH  TVALID per channel
- ch_tready  in  NUM_CH  TREADY per channel
- inst_idle  in  1  instance ap_idle; an idle instance is never blocked
- axis_block_sigs  out  NUM_CH  registered per-channel block flags (to monitor)
- any_block  out  1  OR of axis_block_sigs, registered
- block_enter  out  1  one-cycle pulse on IDLE->BLOCKED
- block_release  out  1  one-cycle pulse on BLOCKED->IDLE
- first_ch  out  5  lowest-index blocked channel captured at block_enter
- first_cycles  out  CNT_W  live stall count of first_ch while BLOCKED, frozen after release

Behaviour:
- Reset (clock and reset as decided): all counters 0, axis_block_sigs 0, any_block 0, pulses 0, first_ch 0, first_cycles 0, FSM in S_IDLE.
- Stall condition per channel i:
  - Input channel: stall_i = ch_tready[i] & ~ch_tvalid[i].
  - Output channel: stall_i = ch_tvalid[i] & ~ch_tready[i].
  - stall_i is gated by ~inst_idle.
- Counter cnt_i:
  - stall_i=1: cnt_i <= cnt_i+1, saturating at 2^CNT_W-1; never wraps.
  - stall_i=0 (handshake, both low, or idle): cnt_i <= 0.
- Flag timing:
  - axis_block_sigs[i] sets at the edge ending the STALL_THRESH-th consecutive stall cycle (stall_i & cnt_i == STALL_THRESH-1). With STALL_THRESH=1, it is set one edge after stall begins.
  - The flag clears at the edge ending the first non-stall cycle.
  - A completed handshake and the flag clearing on the same edge is legal.
- any_block is registered from the next-state OR of the flags, so it changes on the same edge as the flags.
- FSM:
  - S_IDLE -> S_BLOCKED when any next-state flag is 1. On that edge: block_enter=1, first_ch = lowest index set, first_cycles = that counter's next value.
  - S_BLOCKED: first_cycles tracks cnt[first_ch]. first_ch does not change even if first_ch clears while other channels stay blocked. In that case first_cycles holds its last value.
  - S_BLOCKED -> S_IDLE when all next-state flags are 0. On that edge: block_release=1; first_ch and first_cycles hold.
- Simultaneous events:
  - Several channels crossing threshold on the same edge: one block_enter; first_ch is the lowest index.
  - Release and a new block on the same edge are impossible, because the flags are one vector.
- inst_idle asserted mid-block: all counters and flags clear on the next edge; release pulses if the FSM was in S_BLOCKED.
- Reset mid-operation: immediate return to reset values; no release pulse.
- Inputs are sampled only at the clock; no combinational input-to-output path.

Decomposition:
- Shared package axis_block_pkg:
  - FSM state typedef (S_IDLE, S_BLOCKED).
  - Function lowest_set_index(vector).
  - Localparam CNT_MAX = 2^CNT_W-1.
- One sub-module, axis_stall_counter, instantiated per channel: stall detect, saturating counter, flag register. The top holds the generate loop, FSM and capture registers.

Test Plan:
- Setup for tests 1-3: NUM_CH=1, IN_MASK=1, STALL_THRESH=4.
- 1: tready=1, tvalid=0 from cycle 0 -> flag=1 after edge 4, block_enter pulse at edge 4, first_ch=0, first_cycles=4; tvalid=1 at cycle 10 -> flag=0 and block_release after edge 11.
- 2: stall for 3 cycles, 1 handshake, stall for 3 more -> flag never asserts, no pulses.
- 3: CNT_W=3, STALL_THRESH=2, hold stall for 20 cycles -> first_cycles saturates at 7, no wrap, flag stays 1.
- 4: NUM_CH=3, IN_MASK=3'b001; ch2 (output) and ch1 (output) both stall (tvalid=1, tready=0) from the same cycle -> single block_enter, first_ch=1, axis_block_sigs=3'b110.
- 5: channel blocked, then inst_idle=1 -> all flags 0 and block_release on the next edge; counters restart from 0 after idle drops.
- 6: channel blocked, then reset pulsed for 1 cycle -> outputs return to reset values with no block_release; re-stall re-detects after STALL_THRESH cycles.
